iterative_shifter: RTL and testbench
====================================

ITERATIVE_SHIFTER -- requirements
Module: iterative_shifter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; ports are named clock and reset.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state.
REQ-004 ctrl_sll  input  1  start a logical left shift; sampled on a rising edge.
REQ-005 ctrl_sra  input  1  start an arithmetic right shift; sampled on a rising edge.
REQ-006 data_in  input  32  operand; captured on an accepted start.
REQ-007 shamt  input  5  shift amount, 0..31; captured on an accepted start.
REQ-008 data_out  output  32  result register.
REQ-009 data_resultRDY  output  1  one-cycle pulse marking data_out valid.
REQ-010 busy  output  1  high while an operation is in flight (SHIFT state).

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-012 A start SHALL be accepted only in IDLE or DONE, when ctrl_sll or ctrl_sra is high; the block captures data_in, shamt and op, clears the stage index to 0 and enters SHIFT.
REQ-013 Stage index k = 0..4 SHALL apply a shift of 16, 8, 4, 2, 1 respectively, one stage per SHIFT cycle, only when shamt bit (4-k) is set; otherwise the working value passes through unchanged.
REQ-014 sra SHALL fill vacated high bits with bit 31 of the working value; sll SHALL fill vacated low bits with 0.
REQ-015 After stage 4 the FSM SHALL enter DONE, load data_out and assert data_resultRDY for exactly that cycle.
REQ-016 Latency SHALL be fixed: start sampled at edge N gives data_resultRDY high in the cycle after edge N+5.
REQ-017 ctrl_sll and ctrl_sra asserted together SHALL be treated as sll.
REQ-018 Start requests while in SHIFT SHALL be ignored and have no side effects.
REQ-019 A start accepted in DONE SHALL begin a new operation; the current data_resultRDY pulse still completes.
REQ-020 DONE with no start SHALL return to IDLE.
REQ-021 data_out SHALL hold its value until the next DONE.
REQ-022 busy SHALL equal (state == SHIFT).

Reset
REQ-023 Reset SHALL force IDLE, data_out = 0, data_resultRDY = 0, busy = 0 and the working register = 0, including when asserted mid-operation.
REQ-024 The aborted operation SHALL produce no data_resultRDY.

Configuration
REQ-025 Macro SHIFT_EARLY_EXIT_EN: when defined, the FSM SHALL enter DONE at the edge where no shamt bits at or below the current stage remain set.
- shamt = 0 gives data_resultRDY in the cycle after edge N+1.
- Variable latency in this mode = 1 + index of the lowest set shamt stage.
REQ-026 When SHIFT_EARLY_EXIT_EN is undefined, latency SHALL be fixed per REQ-016.

Structure
REQ-027 A shared package SHALL hold the FSM state encodings, the stage amount table (16, 8, 4, 2, 1), and the word-width and shamt-width constants.
REQ-028 One sub-module, shift_stage, SHALL implement a combinational single-stage shift (value, amount, op) and be instantiated once in the datapath.

Verification
REQ-029 The bench SHALL cover:
- sra, data_in = 0x80000000, shamt = 8 -> data_out = 0xFF800000; data_resultRDY after 6 cycles.
- sll, data_in = 0x00000001, shamt = 31 -> data_out = 0x80000000.
- sra, data_in = 0x7FFFFFF0, shamt = 0 -> data_out = 0x7FFFFFF0; latency 6 cycles without the macro, 2 with it.
- Second start pulsed while busy -> ignored; only the first result appears, with one data_resultRDY.
- reset asserted at SHIFT cycle 3 -> data_out = 0, no data_resultRDY, FSM in IDLE; the next start completes normally.
- Back-to-back start accepted in DONE -> two consecutive results, each with a one-cycle data_resultRDY.

Source files
------------

// File: rtl/iterative_shifter_pkg.sv
// Shared definitions for the iterative barrel shifter: widths, FSM states,
// operation codes and the per-stage shift amount table.
package iterative_shifter_pkg;

    localparam int WORD_W  = 32;
    localparam int SHAMT_W = 5;
    localparam int STAGE_N = 5;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic {
        OP_SLL = 1'b0,
        OP_SRA = 1'b1
    } op_e;

    // Entry k is the distance applied by stage k (index 0 is the 16-bit stage).
    localparam logic [STAGE_N-1:0][SHAMT_W-1:0] STAGE_AMT =
        {5'd1, 5'd2, 5'd4, 5'd8, 5'd16};

    function automatic logic [SHAMT_W-1:0] stage_amount(
        input logic [IDX_W-1:0]   k,
        input logic [SHAMT_W-1:0] sh
    );
        case (k)
            3'd0:    stage_amount = sh[4] ? STAGE_AMT[0] : 5'd0;
            3'd1:    stage_amount = sh[3] ? STAGE_AMT[1] : 5'd0;
            3'd2:    stage_amount = sh[2] ? STAGE_AMT[2] : 5'd0;
            3'd3:    stage_amount = sh[1] ? STAGE_AMT[3] : 5'd0;
            3'd4:    stage_amount = sh[0] ? STAGE_AMT[4] : 5'd0;
            default: stage_amount = 5'd0;
        endcase
    endfunction

    // shamt bits still to be applied by the stages after stage k.
    function automatic logic [SHAMT_W-1:0] remaining_mask(
        input logic [IDX_W-1:0] k
    );
        case (k)
            3'd0:    remaining_mask = 5'b01111;
            3'd1:    remaining_mask = 5'b00111;
            3'd2:    remaining_mask = 5'b00011;
            3'd3:    remaining_mask = 5'b00001;
            default: remaining_mask = 5'b00000;
        endcase
    endfunction

endpackage

// File: rtl/iterative_shifter_stage.sv
// Combinational single-stage shifter: logical left or arithmetic right by amount.
module shift_stage
    import iterative_shifter_pkg::*;
(
    input  logic [WORD_W-1:0]  value,
    input  logic [SHAMT_W-1:0] amount,
    input  op_e                op,
    output logic [WORD_W-1:0]  result
);

    // Select the shift direction; an amount of zero passes the value through.
    always_comb begin
        result = value;
        case (op)
            OP_SLL:  result = value << amount;
            OP_SRA:  result = $signed(value) >>> amount;
            default: result = value;
        endcase
    end

endmodule

// File: rtl/iterative_shifter.sv
// Iterative 32-bit shifter applying one power-of-two stage per cycle.
// Optional macro SHIFT_EARLY_EXIT_EN finishes once no further shamt bits remain.
module iterative_shifter
    import iterative_shifter_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_sll,
    input  logic               ctrl_sra,
    input  logic [WORD_W-1:0]  data_in,
    input  logic [SHAMT_W-1:0] shamt,
    output logic [WORD_W-1:0]  data_out,
    output logic               data_resultRDY,
    output logic               busy
);

    state_e             state_r;
    state_e             next_state_s;
    logic [IDX_W-1:0]   k_r;
    logic [WORD_W-1:0]  work_r;
    logic [SHAMT_W-1:0] shamt_r;
    op_e                op_r;
    logic [WORD_W-1:0]  data_out_r;
    logic               rdy_r;

    logic               start_s;
    logic               last_s;
    logic [SHAMT_W-1:0] amount_s;
    logic [WORD_W-1:0]  stage_out_s;

    assign start_s  = ctrl_sll | ctrl_sra;
    assign amount_s = stage_amount(k_r, shamt_r);

`ifdef SHIFT_EARLY_EXIT_EN
    assign last_s = (k_r == 3'd4) || ((shamt_r & remaining_mask(k_r)) == 5'd0);
`else
    assign last_s = (k_r == 3'd4);
`endif

    shift_stage u_stage (
        .value  (work_r),
        .amount (amount_s),
        .op     (op_r),
        .result (stage_out_s)
    );

    // Next-state logic; starts are honoured only outside SHIFT.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) next_state_s = ST_SHIFT;
                else         next_state_s = ST_IDLE;
            end
            ST_SHIFT: begin
                if (last_s) next_state_s = ST_DONE;
                else        next_state_s = ST_SHIFT;
            end
            ST_DONE: begin
                if (start_s) next_state_s = ST_SHIFT;
                else         next_state_s = ST_IDLE;
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_r <= ST_IDLE;
        else       state_r <= next_state_s;
    end

    // Datapath: capture operands on start, step the working value, publish result.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            k_r        <= 3'd0;
            work_r     <= 32'd0;
            shamt_r    <= 5'd0;
            op_r       <= OP_SLL;
            data_out_r <= 32'd0;
            rdy_r      <= 1'b0;
        end else begin
            rdy_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start_s) begin
                        work_r  <= data_in;
                        shamt_r <= shamt;
                        op_r    <= ctrl_sll ? OP_SLL : OP_SRA;
                        k_r     <= 3'd0;
                    end
                end
                ST_SHIFT: begin
                    work_r <= stage_out_s;
                    if (last_s) begin
                        data_out_r <= stage_out_s;
                        rdy_r      <= 1'b1;
                    end else begin
                        k_r <= k_r + 3'd1;
                    end
                end
                default: rdy_r <= 1'b0;
            endcase
        end
    end

    assign data_out       = data_out_r;
    assign data_resultRDY = rdy_r;
    assign busy           = (state_r == ST_SHIFT);

endmodule

// File: tb/tb_iterative_shifter.sv
// Directed self-checking bench for iterative_shifter with an expected-result queue.
module tb_iterative_shifter;

    logic        clock;
    logic        reset;
    logic        ctrl_sll;
    logic        ctrl_sra;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [31:0] data_out;
    logic        data_resultRDY;
    logic        busy;

    int total;
    int bad;
    int cycle;

    typedef struct {
        logic [31:0] data;
        int          start;
        int          lat;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    iterative_shifter dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_sll       (ctrl_sll),
        .ctrl_sra       (ctrl_sra),
        .data_in        (data_in),
        .shamt          (shamt),
        .data_out       (data_out),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [31:0] model(input bit sll, input logic [31:0] d,
                                          input logic [4:0] s);
        logic signed [31:0] t;
        t = d;
        if (sll) model = d << s;
        else     model = t >>> s;
    endfunction

    function automatic int model_lat(input logic [4:0] s);
        int last;
        last = 4;
`ifdef SHIFT_EARLY_EXIT_EN
        last = 0;
        for (int k = 0; k < 5; k++) if (s[4-k]) last = k;
`endif
        model_lat = last + 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want)
        else begin
            bad++;
            $error("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Called at a negedge; drives a one-cycle start request.
    task automatic start(input bit sll, input bit sra, input logic [31:0] d,
                         input logic [4:0] s, input string tag, input bit push);
        exp_t e;
        ctrl_sll = sll;
        ctrl_sra = sra;
        data_in  = d;
        shamt    = s;
        if (push) begin
            e.data  = model(sll, d, s);
            e.start = cycle + 1;
            e.lat   = model_lat(s);
            e.tag   = tag;
            exp_q.push_back(e);
        end
        @(negedge clock);
        ctrl_sll = 1'b0;
        ctrl_sra = 1'b0;
    endtask

    task automatic wait_result();
        int   n;
        exp_t e;
        n = 0;
        while (data_resultRDY !== 1'b1 && n < 40) begin
            @(negedge clock);
            n++;
        end
        total++;
        assert (n < 40 && exp_q.size() > 0)
        else begin
            bad++;
            $error("FAIL wait_result got=timeout_or_empty want=result");
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (n < 40) begin
                check({e.tag, "_data"}, data_out, e.data);
                check({e.tag, "_lat"}, cycle - e.start + 1, e.lat);
            end
        end
    endtask

    task automatic expect_quiet(input string tag, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            if (data_resultRDY !== 1'b0) seen = 1'b1;
        end
        check(tag, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        cycle    = 0;
        reset    = 1'b1;
        ctrl_sll = 1'b0;
        ctrl_sra = 1'b0;
        data_in  = 32'd0;
        shamt    = 5'd0;
        repeat (2) @(negedge clock);
        check("rst_data", data_out, 32'd0);
        check("rst_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        @(negedge clock);

        start(1'b0, 1'b1, 32'h8000_0000, 5'd8, "sra_sign", 1'b1);
        check("busy_shift", {31'd0, busy}, 32'd1);
        wait_result();
        start(1'b1, 1'b0, 32'h0000_0001, 5'd31, "sll_31", 1'b1);
        wait_result();
        start(1'b0, 1'b1, 32'h7FFF_FFF0, 5'd0, "sra_zero", 1'b1);
        wait_result();

        // Second request while SHIFT must vanish without effect.
        start(1'b0, 1'b1, 32'hF000_0000, 5'd4, "busy_first", 1'b1);
        ctrl_sll = 1'b1;
        data_in  = 32'h1234_5678;
        shamt    = 5'd1;
        @(negedge clock);
        ctrl_sll = 1'b0;
        wait_result();
        expect_quiet("busy_no_extra", 12);

        start(1'b1, 1'b1, 32'h0000_ABCD, 5'd4, "both_sll", 1'b1);
        wait_result();

        // Reset in the third SHIFT cycle aborts the operation.
        start(1'b1, 1'b0, 32'h0000_0001, 5'd31, "abort", 1'b0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        #1;
        check("abort_data", data_out, 32'd0);
        check("abort_rdy", {31'd0, data_resultRDY}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        expect_quiet("abort_no_rdy", 8);
        check("abort_idle", {31'd0, busy}, 32'd0);
        start(1'b1, 1'b0, 32'h0000_0001, 5'd31, "after_abort", 1'b1);
        wait_result();

        // Back-to-back: new start sampled while DONE.
        start(1'b0, 1'b1, 32'h8000_00F0, 5'd3, "b2b_a", 1'b1);
        wait_result();
        start(1'b1, 1'b0, 32'hDEAD_BEEF, 5'd16, "b2b_b", 1'b1);
        check("b2b_pulse", {31'd0, data_resultRDY}, 32'd0);
        check("b2b_busy", {31'd0, busy}, 32'd1);
        wait_result();

        for (int i = 0; i < 6; i++) begin
            bit sel;
            sel = 1'($urandom_range(1, 0));
            start(sel, ~sel, 32'($urandom), 5'($urandom_range(31, 0)), "rand", 1'b1);
            wait_result();
        end

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
